// File: rtl/jpeg_output_rgb_conv_if.sv
// Signal bundle between the Y/Cb/Cr sample FIFOs, the RGB converter and the pixel sink.
`timescale 1ns/1ps
interface jpeg_output_rgb_conv_if #(
  parameter int COORD_W = 16
);
  logic               start_i;
  logic [COORD_W-1:0] img_width_i;
  logic [COORD_W-1:0] img_height_i;
  logic               mono_i;
  logic [31:0]        y_data_i;
  logic [31:0]        cb_data_i;
  logic [31:0]        cr_data_i;
  logic               y_valid_i;
  logic               cb_valid_i;
  logic               cr_valid_i;
  logic               y_pop_o;
  logic               cb_pop_o;
  logic               cr_pop_o;
  logic               outport_valid_o;
  logic               outport_accept_i;
  logic [COORD_W-1:0] outport_x_o;
  logic [COORD_W-1:0] outport_y_o;
  logic [7:0]         outport_r_o;
  logic [7:0]         outport_g_o;
  logic [7:0]         outport_b_o;
  logic               idle_o;

  // Handshakes: a FIFO head moves when *_valid_i && *_pop_o at a rising edge; a pixel
  // moves when outport_valid_o && outport_accept_i, and the pixel is held until then.
  modport slave (
    input  start_i, img_width_i, img_height_i, mono_i,
    input  y_data_i, cb_data_i, cr_data_i, y_valid_i, cb_valid_i, cr_valid_i,
    output y_pop_o, cb_pop_o, cr_pop_o,
    output outport_valid_o, outport_x_o, outport_y_o, outport_r_o, outport_g_o, outport_b_o,
    input  outport_accept_i,
    output idle_o
  );

  modport master (
    output start_i, img_width_i, img_height_i, mono_i,
    output y_data_i, cb_data_i, cr_data_i, y_valid_i, cb_valid_i, cr_valid_i,
    input  y_pop_o, cb_pop_o, cr_pop_o,
    input  outport_valid_o, outport_x_o, outport_y_o, outport_r_o, outport_g_o, outport_b_o,
    output outport_accept_i,
    input  idle_o
  );
endinterface

// File: rtl/jpeg_output_rgb_conv.sv
// Pops Y/Cb/Cr samples in lockstep, converts to clamped RGB in a two-stage pipe and
// tags each pixel with its image coordinate; pixels outside the image are dropped.
`timescale 1ns/1ps
module jpeg_output_rgb_conv #(
  parameter int COORD_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  jpeg_output_rgb_conv_if.slave bus
);
  localparam int EW = COORD_W + 4;

  logic               advance;
  logic               take;
  logic [5:0]         idx;
  logic [COORD_W-1:0] blk_x;
  logic [COORD_W-1:0] blk_y;
  logic [EW-1:0]      bx_end;
  logic [EW-1:0]      by_end;
  logic               bx_last;
  logic               by_last;

  logic               s1_valid;
  logic [7:0]         s1_y;
  logic [7:0]         s1_cb;
  logic [7:0]         s1_cr;
  logic [5:0]         s1_idx;
  logic [COORD_W-1:0] s1_bx;
  logic [COORD_W-1:0] s1_by;

  logic               s2_valid;
  logic [COORD_W-1:0] s2_x;
  logic [COORD_W-1:0] s2_y;
  logic [7:0]         s2_r;
  logic [7:0]         s2_g;
  logic [7:0]         s2_b;

  assign advance = !s2_valid || bus.outport_accept_i;
  assign take    = advance && !bus.start_i && bus.y_valid_i &&
                   (bus.mono_i || (bus.cb_valid_i && bus.cr_valid_i));

  assign bus.y_pop_o  = take;
  assign bus.cb_pop_o = take && !bus.mono_i;
  assign bus.cr_pop_o = take && !bus.mono_i;

  // Block-grid wrap tests, widened so (blk+1)*8 cannot overflow near the max image size.
  assign bx_end  = ({4'd0, blk_x} + EW'(1)) << 3;
  assign by_end  = ({4'd0, blk_y} + EW'(1)) << 3;
  assign bx_last = bx_end >= {4'd0, bus.img_width_i};
  assign by_last = by_end >= {4'd0, bus.img_height_i};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx   <= '0;
      blk_x <= '0;
      blk_y <= '0;
    end else if (bus.start_i) begin
      idx   <= '0;
      blk_x <= '0;
      blk_y <= '0;
    end else if (take) begin
      idx <= idx + 6'd1;
      if (idx == 6'd63) begin
        if (bx_last) begin
          blk_x <= '0;
          blk_y <= by_last ? '0 : blk_y + COORD_W'(1);
        end else begin
          blk_x <= blk_x + COORD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
      s1_cb    <= '0;
      s1_cr    <= '0;
      s1_idx   <= '0;
      s1_bx    <= '0;
      s1_by    <= '0;
    end else if (bus.start_i) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= take;
      if (take) begin
        s1_y   <= bus.y_data_i[7:0];
        s1_cb  <= bus.mono_i ? 8'd128 : bus.cb_data_i[7:0];
        s1_cr  <= bus.mono_i ? 8'd128 : bus.cr_data_i[7:0];
        s1_idx <= idx;
        s1_bx  <= blk_x;
        s1_by  <= blk_y;
      end
    end
  end

  // Conversion in 20-bit signed arithmetic; >>> floors toward minus infinity.
  logic signed [19:0] y_s, cb_s, cr_s;
  logic signed [19:0] r_full, g_full, b_full;
  logic [EW-1:0]      px, py;
  logic               in_img;

  assign y_s    = $signed({12'd0, s1_y});
  assign cb_s   = $signed({12'd0, s1_cb}) - 20'sd128;
  assign cr_s   = $signed({12'd0, s1_cr}) - 20'sd128;
  assign r_full = y_s + ((20'sd359 * cr_s) >>> 8);
  assign g_full = y_s - ((20'sd88 * cb_s + 20'sd183 * cr_s) >>> 8);
  assign b_full = y_s + ((20'sd454 * cb_s) >>> 8);

  assign px     = ({4'd0, s1_bx} << 3) + EW'(s1_idx[2:0]);
  assign py     = ({4'd0, s1_by} << 3) + EW'(s1_idx[5:3]);
  assign in_img = (px < {4'd0, bus.img_width_i}) && (py < {4'd0, bus.img_height_i});

  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    if (v < 0)
      return 8'd0;
    else if (v > 20'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
    end else if (bus.start_i) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid && in_img;
      if (s1_valid && in_img) begin
        s2_x <= px[COORD_W-1:0];
        s2_y <= py[COORD_W-1:0];
        s2_r <= clamp8(r_full);
        s2_g <= clamp8(g_full);
        s2_b <= clamp8(b_full);
      end
    end
  end

  assign bus.outport_valid_o = s2_valid;
  assign bus.outport_x_o     = s2_x;
  assign bus.outport_y_o     = s2_y;
  assign bus.outport_r_o     = s2_r;
  assign bus.outport_g_o     = s2_g;
  assign bus.outport_b_o     = s2_b;
  assign bus.idle_o          = !s1_valid && !s2_valid;

  logic unused_bits;
  assign unused_bits = ^{bus.y_data_i[31:8], bus.cb_data_i[31:8], bus.cr_data_i[31:8],
                         px[EW-1:COORD_W], py[EW-1:COORD_W]};
endmodule

// File: tb/tb_jpeg_output_rgb_conv.sv
// Bench for jpeg_output_rgb_conv: FIFO models, random accept, and a scoreboard fed by
// a sequence-number based reference model of pixel coordinate and colour.
`timescale 1ns/1ps
module tb_jpeg_output_rgb_conv;
  localparam int CW = 16;
  localparam int PW = 2 * CW + 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jpeg_output_rgb_conv_if #(.COORD_W(CW)) bus();
  jpeg_output_rgb_conv #(.COORD_W(CW)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]    yq[$], cbq[$], crq[$];
  logic [PW-1:0] exp_q[$], got_q[$];
  int n_taken = 0;
  int accept_mode = 1;   // 0 = hold low, 1 = always, 2 = random
  int pop_cnt = 0;
  int fire_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [PW-1:0] held;

  function automatic int fdiv256(int a);
    int q;
    q = a / 256;
    if (a < 0 && (a % 256) != 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [7:0] clamp(int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  // Pixel n of the image is sample n%64 of block n/64; blocks walk a ceil(W/8) x ceil(H/8) grid.
  task automatic model_take(int yv, int cbv, int crv);
    int w, h, bpr, rows, blk, i, x, yy, dcb, dcr;
    logic [7:0] r, g, b;
    w = int'(bus.img_width_i);
    h = int'(bus.img_height_i);
    bpr = (w + 7) / 8;
    rows = (h + 7) / 8;
    blk = n_taken / 64;
    i = n_taken % 64;
    x = (blk % bpr) * 8 + i % 8;
    yy = ((blk / bpr) % rows) * 8 + i / 8;
    dcb = cbv - 128;
    dcr = crv - 128;
    r = clamp(yv + fdiv256(359 * dcr));
    g = clamp(yv - fdiv256(88 * dcb + 183 * dcr));
    b = clamp(yv + fdiv256(454 * dcb));
    if (x < w && yy < h) exp_q.push_back({CW'(x), CW'(yy), r, g, b});
    n_taken++;
  endtask

  // FIFO heads, accept and the scoreboard all live on the falling edge.
  always @(negedge clk) begin
    logic [PW-1:0] cur, e;
    logic [7:0] yv, cbv, crv;
    bus.y_valid_i  = yq.size() > 0;
    bus.cb_valid_i = cbq.size() > 0;
    bus.cr_valid_i = crq.size() > 0;
    bus.y_data_i  = $urandom();
    bus.cb_data_i = $urandom();
    bus.cr_data_i = $urandom();
    if (yq.size() > 0)  bus.y_data_i[7:0]  = yq[0];
    if (cbq.size() > 0) bus.cb_data_i[7:0] = cbq[0];
    if (crq.size() > 0) bus.cr_data_i[7:0] = crq[0];
    case (accept_mode)
      0:       bus.outport_accept_i = 1'b0;
      1:       bus.outport_accept_i = 1'b1;
      default: bus.outport_accept_i = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    if (rst_n) begin
      cur = {bus.outport_x_o, bus.outport_y_o, bus.outport_r_o, bus.outport_g_o, bus.outport_b_o};
      if (stall_prev) begin
        vectors++;
        if (cur !== held || bus.outport_valid_o !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold: got %h valid %b, held %h", cur, bus.outport_valid_o, held);
        end
      end
      stall_prev = bus.outport_valid_o && !bus.outport_accept_i;
      held = cur;
      vectors++;
      if (bus.cb_pop_o !== (bus.y_pop_o && !bus.mono_i) || bus.cr_pop_o !== (bus.y_pop_o && !bus.mono_i)) begin
        miscompares++;
        $display("FAIL pop_lockstep: y %b cb %b cr %b mono %b", bus.y_pop_o, bus.cb_pop_o, bus.cr_pop_o, bus.mono_i);
      end
      if (bus.start_i) begin
        vectors++;
        if (bus.y_pop_o !== 1'b0) begin
          miscompares++;
          $display("FAIL pop_during_start: got %b need 0", bus.y_pop_o);
        end
      end
      if (bus.y_pop_o) begin
        pop_cnt++;
        vectors++;
        if (yq.size() == 0 || (!bus.mono_i && (cbq.size() == 0 || crq.size() == 0))) begin
          miscompares++;
          $display("FAIL pop_empty: pop with y %0d cb %0d cr %0d entries", yq.size(), cbq.size(), crq.size());
        end else begin
          yv = yq.pop_front();
          if (bus.mono_i) model_take(int'(yv), 128, 128);
          else begin
            cbv = cbq.pop_front();
            crv = crq.pop_front();
            model_take(int'(yv), int'(cbv), int'(crv));
          end
        end
      end
      if (bus.outport_valid_o && bus.outport_accept_i) begin
        fire_cnt++;
        got_q.push_back(cur);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pixel_extra: got %h, expected none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            miscompares++;
            $display("FAIL pixel: got %h expected %h", cur, e);
          end
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic push(logic [7:0] yv, logic [7:0] cbv, logic [7:0] crv);
    yq.push_back(yv);
    cbq.push_back(cbv);
    crq.push_back(crv);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((yq.size() > 0 || bus.idle_o !== 1'b1 || exp_q.size() > 0) && k < 3000) begin
      sync();
      k++;
    end
    vectors++;
    if (k >= 3000) begin
      miscompares++;
      $display("FAIL drain_timeout: y left %0d expected pixels left %0d", yq.size(), exp_q.size());
    end
  endtask

  task automatic do_start(int w, int h);
    accept_mode = 0;
    sync();
    sync();
    bus.start_i = 1'b1;
    bus.img_width_i = CW'(w);
    bus.img_height_i = CW'(h);
    sync();
    bus.start_i = 1'b0;
    exp_q.delete();
    n_taken = 0;
    stall_prev = 1'b0;
  endtask

  task automatic check_xy(string name, logic [PW-1:0] px, int x, int y);
    vectors++;
    if (px[PW-1 -: CW] !== CW'(x) || px[PW-CW-1 -: CW] !== CW'(y)) begin
      miscompares++;
      $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", name, px[PW-1 -: CW], px[PW-CW-1 -: CW], x, y);
    end
  endtask

  task automatic check_rgb(string name, logic [PW-1:0] px, int r, int g, int b);
    vectors++;
    if (px[23:16] !== 8'(r) || px[15:8] !== 8'(g) || px[7:0] !== 8'(b)) begin
      miscompares++;
      $display("FAIL %s: got %0d/%0d/%0d expected %0d/%0d/%0d", name, px[23:16], px[15:8], px[7:0], r, g, b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (bus.outport_valid_o !== 1'b0 || bus.idle_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_flags: valid %b idle %b, need 0/1", bus.outport_valid_o, bus.idle_o);
    end
    vectors++;
    if ({bus.outport_x_o, bus.outport_y_o, bus.outport_r_o, bus.outport_g_o, bus.outport_b_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h need 0", {bus.outport_x_o, bus.outport_y_o, bus.outport_r_o, bus.outport_g_o, bus.outport_b_o});
    end
    vectors++;
    if ({bus.y_pop_o, bus.cb_pop_o, bus.cr_pop_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_pops: got %b need 000", {bus.y_pop_o, bus.cb_pop_o, bus.cr_pop_o});
    end
    rst_n = 1'b1;
    n_taken = 0;
  endtask

  task automatic test_latency();
    accept_mode = 1;
    sync();
    push(8'd128, 8'd128, 8'd128);
    @(negedge clk); #2;
    vectors++;
    if (bus.y_pop_o !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_pop: got %b need 1", bus.y_pop_o);
    end
    @(negedge clk); #2;
    vectors++;
    if (bus.outport_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: valid %b need 0 one cycle after pop", bus.outport_valid_o);
    end
    @(negedge clk); #2;
    vectors++;
    if (bus.outport_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_valid: valid %b need 1 two cycles after pop", bus.outport_valid_o);
    end
    check_xy("latency_xy", {bus.outport_x_o, bus.outport_y_o, bus.outport_r_o, bus.outport_g_o, bus.outport_b_o}, 0, 0);
    check_rgb("latency_rgb", {bus.outport_x_o, bus.outport_y_o, bus.outport_r_o, bus.outport_g_o, bus.outport_b_o}, 128, 128, 128);
    wait_drain();
  endtask

  task automatic test_colors();
    got_q.delete();
    sync();
    push(8'd76, 8'd85, 8'd255);
    push(8'd255, 8'd128, 8'd255);
    push(8'd0, 8'd0, 8'd128);
    wait_drain();
    vectors++;
    if (got_q.size() != 3) begin
      miscompares++;
      $display("FAIL colors_count: got %0d need 3", got_q.size());
    end else begin
      check_rgb("colors_red", got_q[0], 254, 0, 0);
      check_rgb("colors_rclamp", got_q[1], 255, 165, 255);
      check_rgb("colors_green", got_q[2], 0, 44, 0);
    end
  endtask

  task automatic test_mono();
    bus.mono_i = 1'b1;
    got_q.delete();
    sync();
    repeat (3) yq.push_back(8'd200);
    wait_drain();
    bus.mono_i = 1'b0;
    vectors++;
    if (got_q.size() != 3) begin
      miscompares++;
      $display("FAIL mono_count: got %0d need 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) check_rgb("mono_rgb", got_q[i], 200, 200, 200);
    end
  endtask

  task automatic test_random();
    do_start(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)));
    accept_mode = 2;
    for (int i = 0; i < 200; i++)
      push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    wait_drain();
  endtask

  task automatic test_frame();
    int fire0, bad;
    do_start(20, 12);
    accept_mode = 2;
    got_q.delete();
    fire0 = fire_cnt;
    for (int i = 0; i < 384; i++)
      push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    wait_drain();
    vectors++;
    if (fire_cnt - fire0 != 240) begin
      miscompares++;
      $display("FAIL frame_count: got %0d need 240", fire_cnt - fire0);
    end
    bad = 0;
    foreach (got_q[i])
      if (got_q[i][PW-1 -: CW] >= 20 || got_q[i][PW-CW-1 -: CW] >= 12) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL frame_bounds: %0d pixels outside 20x12, need 0", bad);
    end
    if (got_q.size() > 0) check_xy("frame_last", got_q[got_q.size() - 1], 19, 11);
    got_q.delete();
    sync();
    push(8'd10, 8'd128, 8'd128);
    wait_drain();
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL frame_wrap_count: got %0d need 1", got_q.size());
    end else check_xy("frame_wrap", got_q[0], 0, 0);
  endtask

  task automatic test_stall();
    int pop0, fire0;
    do_start(64, 64);
    pop0 = pop_cnt;
    fire0 = fire_cnt;
    for (int i = 0; i < 20; i++)
      push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    repeat (10) sync();
    vectors++;
    if (pop_cnt - pop0 != 2) begin
      miscompares++;
      $display("FAIL stall_pops: got %0d need 2", pop_cnt - pop0);
    end
    accept_mode = 1;
    wait_drain();
    vectors++;
    if (fire_cnt - fire0 != 20) begin
      miscompares++;
      $display("FAIL stall_release: got %0d pixels need 20", fire_cnt - fire0);
    end
  endtask

  task automatic test_start();
    accept_mode = 2;
    sync();
    for (int i = 0; i < 40; i++)
      push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    repeat (12) sync();
    do_start(64, 64);
    vectors++;
    if (bus.idle_o !== 1'b1) begin
      miscompares++;
      $display("FAIL start_idle: got %b need 1", bus.idle_o);
    end
    got_q.delete();
    accept_mode = 1;
    wait_drain();
    vectors++;
    if (got_q.size() == 0) begin
      miscompares++;
      $display("FAIL start_count: got 0 pixels after start, need some");
    end else check_xy("start_first", got_q[0], 0, 0);
  endtask

  task automatic test_async_reset();
    accept_mode = 1;
    sync();
    for (int i = 0; i < 40; i++)
      push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    repeat (6) sync();
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.outport_valid_o !== 1'b0 || bus.idle_o !== 1'b1 || bus.outport_x_o !== '0 || bus.outport_r_o !== '0) begin
      miscompares++;
      $display("FAIL async_reset: valid %b idle %b x %0d r %0d, need 0/1/0/0", bus.outport_valid_o, bus.idle_o, bus.outport_x_o, bus.outport_r_o);
    end
    yq.delete();
    cbq.delete();
    crq.delete();
    exp_q.delete();
    n_taken = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #3;
    rst_n = 1'b1;
    got_q.delete();
    sync();
    push(8'd50, 8'd128, 8'd128);
    wait_drain();
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL async_count: got %0d need 1", got_q.size());
    end else check_xy("async_first", got_q[0], 0, 0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.img_width_i = CW'(64);
    bus.img_height_i = CW'(64);
    bus.mono_i = 1'b0;
    bus.outport_accept_i = 1'b0;
    bus.y_valid_i = 1'b0;
    bus.cb_valid_i = 1'b0;
    bus.cr_valid_i = 1'b0;
    bus.y_data_i = '0;
    bus.cb_data_i = '0;
    bus.cr_data_i = '0;
    test_reset();
    test_latency();
    test_colors();
    test_mono();
    test_random();
    test_frame();
    test_stall();
    test_start();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
